// File: rtl/end_screen_if.sv
// Game-over screen bundle: restart handshake (fail/win/repeatRst) plus LED matrix and buzzer.
interface end_screen_if;
  logic       fail;
  logic       win;
  logic [7:0] hang;
  logic [7:0] red;
  logic [7:0] green;
  logic       beep;
  logic       repeatRst;

  // Game controller side
  modport master (
    output fail, win,
    input  hang, red, green, beep, repeatRst
  );

  // Display driver side
  modport slave (
    input  fail, win,
    output hang, red, green, beep, repeatRst
  );
endinterface

// File: rtl/end_screen_display.sv
// Game-over screen driver: scans a crying (red) or smiling (green) face on an 8x8 matrix,
// beeps at a result-dependent pitch, then requests a restart until fail/win are released.
module end_screen_display #(
  parameter int unsigned SCAN_DIV       = 2,
  parameter int unsigned SHOW_CYCLES    = 2500,
  parameter int unsigned TONE_HALF_FAIL = 1000,
  parameter int unsigned TONE_HALF_WIN  = 500,
  parameter int unsigned CNT_W          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  end_screen_if.slave  bus
);

  localparam logic [CNT_W-1:0] ScanLast     = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] ShowLast     = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ToneLastFail = CNT_W'(TONE_HALF_FAIL - 1);
  localparam logic [CNT_W-1:0] ToneLastWin  = CNT_W'(TONE_HALF_WIN - 1);

  typedef enum logic [1:0] {StIdle, StShowFail, StShowWin, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic [CNT_W-1:0] show_q, show_d;
  logic [CNT_W-1:0] tone_q, tone_d;
  logic             beep_q, beep_d;
  logic [7:0]       hang_q, hang_d;
  logic [7:0]       red_q, red_d;
  logic [7:0]       green_q, green_d;
  logic             rrst_q, rrst_d;
  logic [CNT_W-1:0] tone_last;

  function automatic logic [7:0] cry_row(input logic [2:0] r);
    case (r)
      3'd0: cry_row = 8'h81;
      3'd1: cry_row = 8'h42;
      3'd2: cry_row = 8'h24;
      3'd3: cry_row = 8'h42;
      3'd4: cry_row = 8'h81;
      3'd5: cry_row = 8'h18;
      3'd6: cry_row = 8'h24;
      3'd7: cry_row = 8'h42;
    endcase
  endfunction

  function automatic logic [7:0] smile_row(input logic [2:0] r);
    case (r)
      3'd0: smile_row = 8'h00;
      3'd1: smile_row = 8'h66;
      3'd2: smile_row = 8'h66;
      3'd3: smile_row = 8'h00;
      3'd4: smile_row = 8'h81;
      3'd5: smile_row = 8'h42;
      3'd6: smile_row = 8'h3C;
      3'd7: smile_row = 8'h00;
    endcase
  endfunction

  // Next-state, counters, and registered output values for the state being entered
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    scan_d    = scan_q;
    show_d    = show_q;
    tone_d    = tone_q;
    beep_d    = 1'b0;
    hang_d    = 8'hFF;
    red_d     = 8'h00;
    green_d   = 8'h00;
    rrst_d    = 1'b0;
    tone_last = (state_q == StShowWin) ? ToneLastWin : ToneLastFail;

    unique case (state_q)
      StIdle: begin
        // fail wins a tie
        if (bus.fail || bus.win) begin
          state_d = bus.fail ? StShowFail : StShowWin;
          row_d   = 3'd0;
          scan_d  = '0;
          show_d  = '0;
          tone_d  = '0;
        end
      end
      StShowFail, StShowWin: begin
        if (show_q == ShowLast) begin
          state_d = StDone;
        end else begin
          show_d = show_q + 1'b1;
          if (scan_q == ScanLast) begin
            scan_d = '0;
            row_d  = row_q + 3'd1;  // 7 wraps to 0
          end else begin
            scan_d = scan_q + 1'b1;
          end
          if (tone_q == tone_last) begin
            tone_d = '0;
            beep_d = ~beep_q;
          end else begin
            tone_d = tone_q + 1'b1;
            beep_d = beep_q;
          end
        end
      end
      StDone: begin
        if (!bus.fail && !bus.win) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs follow the state being entered so they line up with it on the same edge
    unique case (state_d)
      StShowFail: begin
        hang_d = ~(8'h80 >> row_d);
        red_d  = cry_row(row_d);
      end
      StShowWin: begin
        hang_d  = ~(8'h80 >> row_d);
        green_d = smile_row(row_d);
      end
      StDone:  rrst_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= 3'd0;
      scan_q  <= '0;
      show_q  <= '0;
      tone_q  <= '0;
      beep_q  <= 1'b0;
      hang_q  <= 8'hFF;
      red_q   <= 8'h00;
      green_q <= 8'h00;
      rrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      scan_q  <= scan_d;
      show_q  <= show_d;
      tone_q  <= tone_d;
      beep_q  <= beep_d;
      hang_q  <= hang_d;
      red_q   <= red_d;
      green_q <= green_d;
      rrst_q  <= rrst_d;
    end
  end

  assign bus.hang      = hang_q;
  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.beep      = beep_q;
  assign bus.repeatRst = rrst_q;

endmodule

// File: tb/tb_end_screen_display.sv
// Bench for end_screen_display: cycle-indexed reference model plus directed literal checks.
module tb_end_screen_display;
  localparam int SCAN = 2;
  localparam int SHOW = 40;
  localparam int HF   = 5;
  localparam int HW   = 3;

  logic clk = 1'b0;
  logic rst_n;
  end_screen_if bus ();

  end_screen_display #(
    .SCAN_DIV      (SCAN),
    .SHOW_CYCLES   (SHOW),
    .TONE_HALF_FAIL(HF),
    .TONE_HALF_WIN (HW),
    .CNT_W         (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] cry   [8] = '{8'h81, 8'h42, 8'h24, 8'h42, 8'h81, 8'h18, 8'h24, 8'h42};
  logic [7:0] smile [8] = '{8'h00, 8'h66, 8'h66, 8'h00, 8'h81, 8'h42, 8'h3C, 8'h00};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 fail show, 2 win show, 3 done; k = cycles since show entry
  int m_mode = 0;
  int m_k    = 0;

  // Model update on each edge and full-output compare 1 time unit later
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0;
        m_k    = 0;
      end else begin
        case (m_mode)
          0: if (bus.fail) begin m_mode = 1; m_k = 0; end
             else if (bus.win) begin m_mode = 2; m_k = 0; end
          1, 2: if (m_k == SHOW - 1) m_mode = 3; else m_k++;
          default: if (!bus.fail && !bus.win) m_mode = 0;
        endcase
      end
      #1;
      begin
        int row, half;
        logic [7:0] e_hang, e_red, e_green;
        logic e_beep;
        row     = (m_k / SCAN) % 8;
        half    = (m_mode == 2) ? HW : HF;
        e_hang  = 8'hFF;
        e_red   = 8'h00;
        e_green = 8'h00;
        e_beep  = 1'b0;
        if (m_mode == 1 || m_mode == 2) begin
          e_hang = ~(8'h80 >> row);
          e_beep = ((m_k / half) % 2) == 1;
        end
        if (m_mode == 1) e_red = cry[row];
        if (m_mode == 2) e_green = smile[row];
        chk("model.hang", bus.hang, e_hang);
        chk("model.red", bus.red, e_red);
        chk("model.green", bus.green, e_green);
        chk("model.beep", {7'd0, bus.beep}, {7'd0, e_beep});
        chk("model.repeatRst", {7'd0, bus.repeatRst}, {7'd0, m_mode == 3});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.fail = 1'b0;
    bus.win  = 1'b0;
    cyc(2);
    chk("rst.hang", bus.hang, 8'hFF);
    chk("rst.repeatRst", {7'd0, bus.repeatRst}, 8'd0);
    rst_n = 1'b1;
    cyc(2);

    // Fail show: entry edge is the next posedge; cycle c is sampled at the c-th negedge after
    bus.fail = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      cyc(1);
      if (c == 0) begin
        chk("fail.c0.hang", bus.hang, 8'h7F);
        chk("fail.c0.red", bus.red, 8'h81);
        chk("fail.c0.beep", {7'd0, bus.beep}, 8'd0);
      end
      if (c == 1) chk("fail.c1.hang", bus.hang, 8'h7F);
      if (c == 2) begin
        chk("fail.c2.hang", bus.hang, 8'hBF);
        chk("fail.c2.red", bus.red, 8'h42);
      end
      if (c == 4) chk("fail.c4.beep", {7'd0, bus.beep}, 8'd0);
      if (c == 5) chk("fail.c5.beep", {7'd0, bus.beep}, 8'd1);
      if (c == 14) chk("fail.c14.hang", bus.hang, 8'hFE);
      if (c == 16) chk("fail.c16.hang", bus.hang, 8'h7F);
      if (c == 39) chk("fail.c39.repeatRst", {7'd0, bus.repeatRst}, 8'd0);
      if (c == 40) chk("fail.c40.repeatRst", {7'd0, bus.repeatRst}, 8'd1);
      if (c == 50) begin
        chk("hold.repeatRst", {7'd0, bus.repeatRst}, 8'd1);
        chk("hold.hang", bus.hang, 8'hFF);
        chk("hold.red", bus.red, 8'h00);
      end
    end
    bus.fail = 1'b0;
    cyc(1);
    chk("release.repeatRst", {7'd0, bus.repeatRst}, 8'd0);
    chk("release.hang", bus.hang, 8'hFF);
    cyc(1);

    // Win show
    bus.win = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      cyc(1);
      if (c == 0) begin
        chk("win.c0.hang", bus.hang, 8'h7F);
        chk("win.c0.green", bus.green, 8'h00);
        chk("win.c0.red", bus.red, 8'h00);
      end
      if (c == 2) chk("win.c2.green", bus.green, 8'h66);
      if (c == 2) chk("win.c2.beep", {7'd0, bus.beep}, 8'd0);
      if (c == 3) chk("win.c3.beep", {7'd0, bus.beep}, 8'd1);
      if (c == 12) chk("win.c12.green", bus.green, 8'h3C);
      if (c == 40) chk("win.c40.repeatRst", {7'd0, bus.repeatRst}, 8'd1);
    end
    bus.win = 1'b0;
    cyc(2);

    // Tie: fail has priority; swapping requests mid-show is ignored
    bus.fail = 1'b1;
    bus.win  = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      cyc(1);
      if (c == 0) chk("tie.c0.red", bus.red, 8'h81);
      if (c == 10) bus.fail = 1'b0;
      if (c == 12) begin
        chk("tie.c12.red", bus.red, 8'h24);
        chk("tie.c12.green", bus.green, 8'h00);
      end
      if (c == 40) chk("tie.c40.repeatRst", {7'd0, bus.repeatRst}, 8'd1);
    end
    bus.win = 1'b0;
    cyc(2);

    // Asynchronous reset mid-show, then a fresh full show
    bus.fail = 1'b1;
    cyc(18);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.hang", bus.hang, 8'hFF);
    chk("arst.red", bus.red, 8'h00);
    chk("arst.repeatRst", {7'd0, bus.repeatRst}, 8'd0);
    cyc(2);
    rst_n = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      cyc(1);
      if (c == 0) chk("post.c0.hang", bus.hang, 8'h7F);
      if (c == 39) chk("post.c39.repeatRst", {7'd0, bus.repeatRst}, 8'd0);
      if (c == 40) chk("post.c40.repeatRst", {7'd0, bus.repeatRst}, 8'd1);
    end
    bus.fail = 1'b0;
    cyc(1);

    // Back-to-back: restart straight into a win show
    bus.win = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      cyc(1);
      if (c == 0) begin
        chk("b2b.c0.hang", bus.hang, 8'h7F);
        chk("b2b.c0.beep", {7'd0, bus.beep}, 8'd0);
      end
    end
    bus.win = 1'b0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
